// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
//   Shares the single register-file write port between the ALU writeback path
//   and the load (MEM) writeback path. Each requester owns a one-entry holding
//   slot. Arbitration looks only at registered slot state, so there is no
//   combinational path from *_valid_i to *_ready_o. The RegDst choice (rt or rd)
//   for ALU results is resolved when the ALU slot is loaded.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   alu_valid_i / alu_ready_o     ALU writeback handshake
//   alu_rt_i, alu_rd_i            ALU destination candidates
//   alu_regdst_i                  0: write rt, 1: write rd
//   alu_data_i                    ALU result
//   mem_valid_i / mem_ready_o     load writeback handshake
//   mem_addr_i, mem_data_i        load destination and data
//   rf_we_o/rf_waddr_o/rf_wdata_o registered register-file write port
//   wb_stall_o                    a valid request is refused this cycle
//
// Build option
//   ZERO_REG_DROP_EN : granted entries addressed to register 0 are consumed
//                      without pulsing rf_we_o.
// -----------------------------------------------------------------------------
module regfile_wr_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              alu_valid_i,
    output logic              alu_ready_o,
    input  logic [ADDR_W-1:0] alu_rt_i,
    input  logic [ADDR_W-1:0] alu_rd_i,
    input  logic              alu_regdst_i,
    input  logic [DATA_W-1:0] alu_data_i,
    input  logic              mem_valid_i,
    output logic              mem_ready_o,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    output logic              wb_stall_o
);

    typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_e;
    typedef enum logic {GNT_ALU = 1'b0, GNT_MEM = 1'b1} gnt_e;

    slot_e             alu_st_q, alu_st_d, mem_st_q, mem_st_d;
    gnt_e              last_gnt_q, last_gnt_d;
    logic [ADDR_W-1:0] alu_addr_q, alu_addr_d, mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] alu_data_q, alu_data_d, mem_data_q, mem_data_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    logic              alu_full, mem_full, gnt_alu, gnt_mem;
    logic              alu_rdy, mem_rdy, alu_acc, mem_acc;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;
    logic              wr_ok;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alu_st_q   <= SLOT_EMPTY;
            mem_st_q   <= SLOT_EMPTY;
            last_gnt_q <= GNT_ALU;
            alu_addr_q <= '0;
            alu_data_q <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            alu_st_q   <= alu_st_d;
            mem_st_q   <= mem_st_d;
            last_gnt_q <= last_gnt_d;
            alu_addr_q <= alu_addr_d;
            alu_data_q <= alu_data_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    always_comb begin
        alu_full = (alu_st_q == SLOT_FULL);
        mem_full = (mem_st_q == SLOT_FULL);

        // On a tie the slot that did not win last time goes; last_gnt resets
        // to ALU so the first tie after reset goes to MEM.
        gnt_alu = alu_full & (~mem_full | (last_gnt_q == GNT_MEM));
        gnt_mem = mem_full & (~alu_full | (last_gnt_q == GNT_ALU));

        // A granted slot drains this edge, so it can refill at the same time.
        alu_rdy = ~alu_full | gnt_alu;
        mem_rdy = ~mem_full | gnt_mem;
        alu_acc = alu_valid_i & alu_rdy;
        mem_acc = mem_valid_i & mem_rdy;

        alu_st_d   = alu_st_q;
        alu_addr_d = alu_addr_q;
        alu_data_d = alu_data_q;
        if (alu_acc) begin
            alu_st_d   = SLOT_FULL;
            alu_addr_d = alu_regdst_i ? alu_rd_i : alu_rt_i;
            alu_data_d = alu_data_i;
        end else if (gnt_alu) begin
            alu_st_d   = SLOT_EMPTY;
        end

        mem_st_d   = mem_st_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        if (mem_acc) begin
            mem_st_d   = SLOT_FULL;
            mem_addr_d = mem_addr_i;
            mem_data_d = mem_data_i;
        end else if (gnt_mem) begin
            mem_st_d   = SLOT_EMPTY;
        end

        last_gnt_d = last_gnt_q;
        if (gnt_alu)      last_gnt_d = GNT_ALU;
        else if (gnt_mem) last_gnt_d = GNT_MEM;

        gnt_addr = gnt_alu ? alu_addr_q : mem_addr_q;
        gnt_data = gnt_alu ? alu_data_q : mem_data_q;

`ifdef ZERO_REG_DROP_EN
        wr_ok = (gnt_addr != '0);
`else
        wr_ok = 1'b1;
`endif

        // Address/data hold when nothing is granted.
        rf_we_d    = (gnt_alu | gnt_mem) & wr_ok;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (gnt_alu | gnt_mem) begin
            rf_waddr_d = gnt_addr;
            rf_wdata_d = gnt_data;
        end
    end

    assign alu_ready_o = alu_rdy;
    assign mem_ready_o = mem_rdy;
    assign rf_we_o     = rf_we_q;
    assign rf_waddr_o  = rf_waddr_q;
    assign rf_wdata_o  = rf_wdata_q;
    assign wb_stall_o  = (alu_valid_i & ~alu_rdy) | (mem_valid_i & ~mem_rdy);

endmodule
